// File: rtl/barrel_shift_pipe.sv
// Purpose : pipelined barrel shifter/rotator (SLL, SRL, ROL, ROR, SRA) with a sideband tag.
// Latency : LAT = $clog2(WIDTH)+2 cycles (input reversal, one level per amount bit, output reversal).
// Backpr. : whole-pipe stall; in_ready = !out_valid | out_ready; every stage holds, bubbles too.
//
// Ports: clk / rst_n (async, active-low); in_valid/in_ready/in_data/in_amt/in_op/in_tag upstream;
//        out_valid/out_ready/out_data/out_tag downstream; out_zero/out_cout only when the
//        BSHIFT_FLAGS_EN macro is defined (result == 0, last bit shifted out).
// in_op: 000 SLL, 001 SRL, 010 ROL, 011 ROR, 1xx SRA.
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
`ifdef BSHIFT_FLAGS_EN
    ,
    output logic                     out_zero,
    output logic                     out_cout
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LAT = SHW + 2;

    // Core stages 0..SHW: stage 0 is the input reversal register, stage k shifts by 2^(k-1).
    logic [SHW:0]              vld_q, vld_d;
    logic [SHW:0][WIDTH-1:0]   dat_q, dat_d;
    logic [SHW:0][TAG_W-1:0]   tag_q, tag_d;
    logic [SHW:0]              rev_q, rev_d;   // right-type op: reverse again at the output
    // Control only needed by the shift levels, so stage SHW does not carry it.
    logic [SHW-1:0][SHW-1:0]   amt_q, amt_d;
    logic [SHW-1:0]            rot_q, rot_d;   // wrap shifted-out bits back in
    logic [SHW-1:0]            fill_q, fill_d; // vacated-bit value for non-rotate ops

    // Output stage (stage SHW+1).
    logic                      out_vld_q, out_vld_d;
    logic [WIDTH-1:0]          out_dat_q, out_dat_d;
    logic [TAG_W-1:0]          out_tag_q, out_tag_d;
`ifdef BSHIFT_FLAGS_EN
    logic [SHW:0]              cout_q, cout_d;
    logic                      out_zero_q, out_zero_d;
    logic                      out_cout_q, out_cout_d;
`endif

    logic adv;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    always_comb begin
        logic [WIDTH-1:0] shl;
        logic [WIDTH-1:0] wrap;
        logic [SHW-1:0]   step;
        logic             take;
        shl  = '0;
        wrap = '0;
        step = '0;
        take = 1'b0;

        adv      = !out_vld_q | out_ready;
        in_ready = adv;

        vld_d     = vld_q;
        dat_d     = dat_q;
        tag_d     = tag_q;
        rev_d     = rev_q;
        amt_d     = amt_q;
        rot_d     = rot_q;
        fill_d    = fill_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_tag_d = out_tag_q;
`ifdef BSHIFT_FLAGS_EN
        cout_d     = cout_q;
        out_zero_d = out_zero_q;
        out_cout_d = out_cout_q;
`endif

        if (adv) begin
            // Stage 0: operand fields are only captured on an actual input transfer.
            vld_d[0] = in_valid;
            if (in_valid) begin
                rev_d[0]  = in_op[2] | in_op[0];
                dat_d[0]  = (in_op[2] | in_op[0]) ? bitrev(in_data) : in_data;
                tag_d[0]  = in_tag;
                amt_d[0]  = in_amt;
                rot_d[0]  = !in_op[2] & in_op[1];
                // Sign fill for SRA; the reversal turns the left-shift LSB fill into MSB fill.
                fill_d[0] = in_op[2] & in_data[WIDTH-1];
`ifdef BSHIFT_FLAGS_EN
                cout_d[0] = 1'b0;
`endif
            end

            // Shift levels: a left-shift-only core; right-type ops were reversed at stage 0.
            for (int k = 1; k <= SHW; k++) begin
                step = SHW'(1) << (k - 1);
                take = (amt_q[k-1] & step) != '0;
                shl  = dat_q[k-1] << (1 << (k - 1));
                if (rot_q[k-1]) begin
                    wrap = dat_q[k-1] >> (WIDTH - (1 << (k - 1)));
                end else begin
                    wrap = fill_q[k-1] ? ~({WIDTH{1'b1}} << (1 << (k - 1))) : '0;
                end
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
                rev_d[k] = rev_q[k-1];
                dat_d[k] = take ? (shl | wrap) : dat_q[k-1];
`ifdef BSHIFT_FLAGS_EN
                // The last active level's outgoing MSB is the overall last bit shifted out.
                cout_d[k] = take ? dat_q[k-1][WIDTH - (1 << (k - 1))] : cout_q[k-1];
`endif
            end
            for (int k = 1; k < SHW; k++) begin
                amt_d[k]  = amt_q[k-1];
                rot_d[k]  = rot_q[k-1];
                fill_d[k] = fill_q[k-1];
            end

            out_vld_d = vld_q[SHW];
            out_dat_d = rev_q[SHW] ? bitrev(dat_q[SHW]) : dat_q[SHW];
            out_tag_d = tag_q[SHW];
`ifdef BSHIFT_FLAGS_EN
            out_zero_d = (out_dat_d == '0);
            out_cout_d = cout_q[SHW];
`else
            // Flag outputs are not built; result path is unchanged.
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            dat_q     <= '0;
            tag_q     <= '0;
            rev_q     <= '0;
            amt_q     <= '0;
            rot_q     <= '0;
            fill_q    <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_tag_q <= '0;
`ifdef BSHIFT_FLAGS_EN
            cout_q     <= '0;
            out_zero_q <= 1'b0;
            out_cout_q <= 1'b0;
`endif
        end else begin
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            tag_q     <= tag_d;
            rev_q     <= rev_d;
            amt_q     <= amt_d;
            rot_q     <= rot_d;
            fill_q    <= fill_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_tag_q <= out_tag_d;
`ifdef BSHIFT_FLAGS_EN
            cout_q     <= cout_d;
            out_zero_q <= out_zero_d;
            out_cout_q <= out_cout_d;
`endif
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_tag   = out_tag_q;
`ifdef BSHIFT_FLAGS_EN
    assign out_zero  = out_zero_q;
    assign out_cout  = out_cout_q;
`endif

    // Keeps LAT visible as the documented latency of this block.
    logic [7:0] lat_unused;
    assign lat_unused = 8'(LAT);

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 32-bit instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_amt;
    logic [2:0]  a_in_op;
    logic [3:0]  a_in_tag, a_out_tag;
    // 8-bit instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_amt;
    logic [2:0]  b_in_op;
    logic [1:0]  b_in_tag, b_out_tag;
`ifdef BSHIFT_FLAGS_EN
    logic        a_out_zero, a_out_cout, b_out_zero, b_out_cout;
`endif

    barrel_shift_pipe #(.WIDTH(32), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_amt(a_in_amt), .in_op(a_in_op), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag)
`ifdef BSHIFT_FLAGS_EN
        , .out_zero(a_out_zero), .out_cout(a_out_cout)
`endif
    );

    barrel_shift_pipe #(.WIDTH(8), .TAG_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag)
`ifdef BSHIFT_FLAGS_EN
        , .out_zero(b_out_zero), .out_cout(b_out_cout)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  tag;
        logic        z;
        logic        c;
        int          t;
        int          lat;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        a_pend, b_pend;
    int          n_chk = 0, n_pass = 0, cyc_cnt = 0;
    logic        a_fired = 1'b0, b_fired = 1'b0;
    logic        a_prev_stall = 1'b0;
    logic [31:0] a_prev_d;
    logic [3:0]  a_prev_tag;
    logic [3:0]  a_tag_ctr = 4'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: plain w-bit arithmetic on a 64-bit carrier, no reversal trick.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d, input int a,
                                              input logic [2:0] op, output logic c);
        logic [63:0] m, x, r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, d} & m;
        c = 1'b0;
        r = x;
        if (a != 0) begin
            if (op[2]) begin
                r = x >> a;
                if (x[w-1]) r = r | (m & ~(m >> a));
                c = x[a-1];
            end else begin
                case (op[1:0])
                    2'd0: begin r = (x << a) & m; c = x[w-a]; end
                    2'd1: begin r = x >> a; c = x[a-1]; end
                    2'd2: begin r = ((x << a) | (x >> (w - a))) & m; c = r[0]; end
                    default: begin r = ((x >> a) | (x << (w - a))) & m; c = r[w-1]; end
                endcase
            end
        end
        return r[31:0];
    endfunction

    function automatic exp_t mk_exp(input int w, input logic [31:0] d, input int a,
                                    input logic [2:0] op, input logic [3:0] tag, input int lat);
        exp_t e;
        logic c;
        e.d   = ref_shift(w, d, a, op, c);
        e.c   = c;
        e.z   = (e.d == 32'd0);
        e.tag = tag;
        e.t   = 0;
        e.lat = lat;
        return e;
    endfunction

    function automatic exp_t dexp(input logic [31:0] d, input logic z, input logic c);
        exp_t e;
        e.d = d; e.z = z; e.c = c; e.tag = 4'd0; e.t = 0; e.lat = 7;
        return e;
    endfunction

    // One clock: called at a negedge with inputs set; samples 2 units later, returns at next negedge.
    task automatic cyc();
        exp_t e;
        #2;
        if (a_prev_stall) begin
            check("a_stall_vld", 64'(a_out_valid), 64'd1);
            check("a_stall_dat", 64'(a_out_data), 64'(a_prev_d));
            check("a_stall_tag", 64'(a_out_tag), 64'(a_prev_tag));
        end
        a_prev_stall = a_out_valid & !a_out_ready;
        a_prev_d     = a_out_data;
        a_prev_tag   = a_out_tag;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_spurious", 64'd1, 64'd0);
            end else begin
                e = qa.pop_front();
                check("a_data", 64'(a_out_data), 64'(e.d));
                check("a_tag", 64'(a_out_tag), 64'(e.tag));
`ifdef BSHIFT_FLAGS_EN
                check("a_zero", 64'(a_out_zero), 64'(e.z));
                check("a_cout", 64'(a_out_cout), 64'(e.c));
`endif
                if (e.lat >= 0) check("a_latency", 64'(cyc_cnt - e.t), 64'(e.lat));
            end
        end
        a_fired = a_in_valid & a_in_ready;
        if (a_fired) begin
            a_pend.t = cyc_cnt;
            qa.push_back(a_pend);
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_spurious", 64'd1, 64'd0);
            end else begin
                e = qb.pop_front();
                check("b_data", 64'(b_out_data), 64'(e.d));
                check("b_tag", 64'(b_out_tag), 64'(e.tag));
`ifdef BSHIFT_FLAGS_EN
                check("b_zero", 64'(b_out_zero), 64'(e.z));
                check("b_cout", 64'(b_out_cout), 64'(e.c));
`endif
                check("b_latency", 64'(cyc_cnt - e.t), 64'(e.lat));
            end
        end
        b_fired = b_in_valid & b_in_ready;
        if (b_fired) begin
            b_pend.t = cyc_cnt;
            qb.push_back(b_pend);
        end
        cyc_cnt++;
        @(negedge clk);
    endtask

    task automatic a_issue(input logic [31:0] d, input int amt, input logic [2:0] op, input exp_t e);
        logic done;
        done       = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_amt   = 5'(amt);
        a_in_op    = op;
        a_in_tag   = a_tag_ctr;
        a_pend     = e;
        a_pend.tag = a_tag_ctr;
        a_tag_ctr++;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = a_fired;
        end
        if (!done) check("a_issue_timeout", 64'd0, 64'd1);
        a_in_valid = 1'b0;
    endtask

    task automatic a_drain();
        for (int i = 0; i < 100 && qa.size() > 0; i++) cyc();
        check("a_drain", 64'(qa.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        logic [31:0] rd;
        int ra;
        logic [2:0] rop;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_op = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_op = '0; b_in_tag = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_vld", 64'(a_out_valid), 64'd0);
        check("rst_a_dat", 64'(a_out_data), 64'd0);
        check("rst_a_tag", 64'(a_out_tag), 64'd0);
        check("rst_b_vld", 64'(b_out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("rel_a_rdy", 64'(a_in_ready), 64'd1);
        check("rel_b_rdy", 64'(b_in_ready), 64'd1);
        @(negedge clk);

        // Directed cases, back-to-back with out_ready high: each must take exactly 7 cycles.
        a_issue(32'h8000_0001, 1,  3'b000, dexp(32'h0000_0002, 1'b0, 1'b1));
        a_drain();
        a_issue(32'h8000_0000, 31, 3'b100, dexp(32'hFFFF_FFFF, 1'b0, 1'b0));
        a_issue(32'h8000_0000, 31, 3'b001, dexp(32'h0000_0001, 1'b0, 1'b0));
        a_issue(32'h0000_0001, 4,  3'b011, dexp(32'h1000_0000, 1'b0, 1'b0));
        a_issue(32'h8000_0000, 1,  3'b010, dexp(32'h0000_0001, 1'b0, 1'b1));
        for (int op = 0; op < 5; op++)
            a_issue(32'hDEAD_BEEF, 0, 3'(op), dexp(32'hDEAD_BEEF, 1'b0, 1'b0));
        a_issue(32'h0000_0001, 31, 3'b000, dexp(32'h8000_0000, 1'b0, 1'b0));
        a_issue(32'h0000_0002, 31, 3'b000, dexp(32'h0000_0000, 1'b1, 1'b1));
        a_drain();

        // Random stream with random downstream backpressure.
        issued = 0;
        for (int i = 0; i < 4000 && (issued < 300 || qa.size() > 0 || a_in_valid); i++) begin
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!a_in_valid || a_fired) begin
                if (issued < 300 && $urandom_range(0, 4) != 0) begin
                    rd  = $urandom;
                    ra  = $urandom_range(0, 31);
                    rop = 3'($urandom_range(0, 7));
                    a_in_valid = 1'b1;
                    a_in_data  = rd;
                    a_in_amt   = 5'(ra);
                    a_in_op    = rop;
                    a_in_tag   = a_tag_ctr;
                    a_pend     = mk_exp(32, rd, ra, rop, a_tag_ctr, -1);
                    a_tag_ctr++;
                    issued++;
                end else begin
                    // Idle: payload lines carry junk that must be ignored.
                    a_in_valid = 1'b0;
                    a_in_data  = $urandom;
                    a_in_amt   = 5'($urandom_range(0, 31));
                    a_in_op    = 3'($urandom_range(0, 7));
                end
            end
            cyc();
        end
        check("stream_issued", 64'(issued), 64'd300);
        check("stream_drained", 64'(qa.size()), 64'd0);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        cyc();

        // Reset with a full pipe: results in flight are discarded.
        for (int i = 0; i < 8; i++) begin
            rd = $urandom;
            ra = $urandom_range(1, 31);
            a_issue(rd, ra, 3'b010, mk_exp(32, rd, ra, 3'b010, 4'd0, 7));
        end
        check("pre_rst_vld", 64'(a_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(a_out_valid), 64'd0);
        check("mid_rst_dat", 64'(a_out_data), 64'd0);
        qa.delete();
        a_prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            check("post_rst_idle", 64'(a_out_valid), 64'd0);
            if (i == 0) check("post_rst_rdy", 64'(a_in_ready), 64'd1);
            @(negedge clk);
        end
        a_issue(32'h0000_00F0, 4, 3'b001, dexp(32'h0000_000F, 1'b0, 1'b0));
        a_drain();

        // 8-bit instance: every operand, amount and op class, one per cycle.
        for (int d = 0; d < 256; d++) begin
            for (int a = 0; a < 8; a++) begin
                for (int op = 0; op < 5; op++) begin
                    b_in_valid = 1'b1;
                    b_in_data  = 8'(d);
                    b_in_amt   = 3'(a);
                    b_in_op    = 3'(op);
                    b_in_tag   = 2'(op + a);
                    b_pend     = mk_exp(8, 32'(d), a, 3'(op), 4'((op + a) & 3), 5);
                    cyc();
                    if (!b_fired) check("b_accept", 64'd0, 64'd1);
                end
            end
        end
        b_in_valid = 1'b0;
        for (int i = 0; i < 50 && qb.size() > 0; i++) cyc();
        check("b_drain", 64'(qb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
